// File: rtl/neopix_pkg.sv
// Shared definitions for the NeoPixel pattern generator: mode encoding and
// the GRB pixel word layout.
package neopix_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_CHASE = 2'd1,
    MODE_FILL  = 2'd2,
    MODE_BLANK = 2'd3
  } mode_e;

  localparam int PIXEL_W = 24;
  localparam int G_OFS   = 16;
  localparam int R_OFS   = 8;
  localparam int B_OFS   = 0;

endpackage

// File: rtl/neopix_frame_timer.sv
// Free-running frame period counter: counts 0..FRAME_DIV-1 and asserts tick
// combinationally during the terminal count.
module neopix_frame_timer #(
  parameter int FRAME_DIV = 524288
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Next count: wrap to zero after the terminal count.
  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/neopix_pattern_gen.sv
// NeoPixel animation engine: frame tick pacing, accept handshake against the
// serializer busy flag, pattern state and per-pixel frame rendering.
// Optional feature macro: NEOPIX_BRIGHTNESS_EN adds a global brightness input
// that scales every channel byte before it is registered into data_out.
module neopix_pattern_gen
  import neopix_pkg::*;
#(
  parameter int NUM_PIXELS = 24,
  parameter int FRAME_DIV  = 524288,
  parameter int MAX_LEVEL  = 100
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          enable,
  input  logic [1:0]                    mode,
`ifdef NEOPIX_BRIGHTNESS_EN
  input  logic [7:0]                    brightness,
`endif
  input  logic                          tx_busy,
  output logic                          start_tx,
  output logic [PIXEL_W*NUM_PIXELS-1:0] data_out,
  output logic                          overrun
);

  // pos needs one value beyond the last pixel for the FILL blank frame.
  localparam int PW = $clog2(NUM_PIXELS + 1);
  localparam logic [7:0]    MAX_L    = 8'(MAX_LEVEL);
  localparam logic [PW-1:0] POS_LAST = PW'(NUM_PIXELS - 1);
  localparam logic [PW-1:0] POS_END  = PW'(NUM_PIXELS);

`ifdef NEOPIX_BRIGHTNESS_EN
  function automatic logic [7:0] scale_level(input logic [7:0] lvl, input logic [7:0] br);
    logic [15:0] prod;
    prod = 16'(lvl) * 16'(br);
    return prod[15:8];
  endfunction
`endif

  logic tick;
  logic tick_en;
  logic accept;
  logic blackout;

  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic vld_p0_q;
  logic start_tx_q;

  logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [1:0]    last_mode_q, last_mode_d;

  logic [PIXEL_W*NUM_PIXELS-1:0] frame_d;
  logic [PIXEL_W*NUM_PIXELS-1:0] data_q;

  neopix_frame_timer #(
    .FRAME_DIV(FRAME_DIV)
  ) u_timer (
    .clk_i (CLK),
    .rst_i (RST),
    .tick_o(tick)
  );

  assign tick_en = tick & enable;
  // The two cycles after an accept are the data/pulse pipeline; holding off
  // there guarantees one start_tx per accepted frame.
  assign blackout = vld_p0_q | start_tx_q;
  assign accept   = enable & ~tx_busy & ~blackout & (pending_q | tick);

  // Pending/overrun bookkeeping: ticks coalesce while a frame waits.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (tick_en && pending_q) overrun_d = 1'b1;
    if (accept)       pending_d = 1'b0;
    else if (tick_en) pending_d = 1'b1;
  end

  // Animation state step on accept; a mode change restarts from zero.
  always_comb begin
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    pos_d       = pos_q;
    last_mode_d = last_mode_q;
    if (accept) begin
      last_mode_d = mode;
      if (mode != last_mode_q) begin
        r_d   = '0;
        g_d   = '0;
        b_d   = '0;
        pos_d = '0;
      end else begin
        case (mode)
          MODE_RAMP: begin
            if (r_q < MAX_L)      r_d = r_q + 8'd1;
            else if (g_q < MAX_L) g_d = g_q + 8'd1;
            else if (b_q < MAX_L) b_d = b_q + 8'd1;
            else begin
              r_d = '0;
              g_d = '0;
              b_d = '0;
            end
          end
          MODE_CHASE: pos_d = (pos_q >= POS_LAST) ? '0 : pos_q + PW'(1);
          MODE_FILL:  pos_d = (pos_q >= POS_END)  ? '0 : pos_q + PW'(1);
          default: ;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_pix
    localparam int PH = i % 3;
    localparam logic [PW-1:0] IDX = PW'(i);
    logic [7:0] g_c, r_c, b_c;
    logic [PIXEL_W-1:0] pix;

    // Channel levels for this pixel from the post-step state.
    always_comb begin
      g_c = '0;
      r_c = '0;
      b_c = '0;
      case (mode)
        MODE_RAMP: begin
          if (PH == 0)      r_c = r_d;
          else if (PH == 1) g_c = g_d;
          else              b_c = b_d;
        end
        MODE_CHASE: begin
          if (pos_d == IDX) begin
            g_c = MAX_L;
            r_c = MAX_L;
            b_c = MAX_L;
          end
        end
        MODE_FILL: begin
          if ((IDX <= pos_d) && (pos_d < POS_END)) begin
            if (PH == 0)      r_c = MAX_L;
            else if (PH == 1) g_c = MAX_L;
            else              b_c = MAX_L;
          end
        end
        default: ;
      endcase
    end

    // Pack the GRB word, optionally scaled by the global brightness.
    always_comb begin
      pix = '0;
`ifdef NEOPIX_BRIGHTNESS_EN
      pix[G_OFS +: 8] = scale_level(g_c, brightness);
      pix[R_OFS +: 8] = scale_level(r_c, brightness);
      pix[B_OFS +: 8] = scale_level(b_c, brightness);
`else
      pix[G_OFS +: 8] = g_c;
      pix[R_OFS +: 8] = r_c;
      pix[B_OFS +: 8] = b_c;
`endif
    end

    assign frame_d[(NUM_PIXELS-i)*PIXEL_W-1 -: PIXEL_W] = pix;
  end

  // State, frame register and the two-stage start pulse pipeline.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      vld_p0_q    <= 1'b0;
      start_tx_q  <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      pos_q       <= '0;
      last_mode_q <= '0;
      data_q      <= '0;
    end else begin
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      vld_p0_q    <= accept;
      start_tx_q  <= vld_p0_q;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      pos_q       <= pos_d;
      last_mode_q <= last_mode_d;
      if (accept) data_q <= frame_d;
    end
  end

  assign start_tx = start_tx_q;
  assign data_out = data_q;
  assign overrun  = overrun_q;

endmodule
